// File: rtl/kgd_scanout.sv
// kgd_scanout: raster scan-out reader for the KGD 1-bpp video RAM.
// Generates the horizontal/vertical timing counters, walks the port B read
// address in raster order and registers the returned pixel together with
// sync and data-enable so that all video outputs leave on the same strobe.
module kgd_scanout #(
    parameter int H_ACTIVE = 400,
    parameter int H_TOTAL  = 512,
    parameter int HS_START = 432,
    parameter int HS_WIDTH = 48,
    parameter int V_ACTIVE = 288,
    parameter int V_TOTAL  = 312,
    parameter int VS_START = 292,
    parameter int VS_WIDTH = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        pix_ce,
    input  logic        enable,
    input  logic        invert,
    output logic [16:0] vram_addr,
    input  logic        vram_q,
    output logic        video,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    // One extra bit of headroom so a sync window ending exactly at the
    // total count is still representable.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(HS_START);
    localparam logic [HW-1:0] HS_END = HW'(HS_START + HS_WIDTH);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(VS_START);
    localparam logic [VW-1:0] VS_END = VW'(VS_START + VS_WIDTH);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;

    logic h_wrap;
    logic v_wrap;
    logic act;
    logic hs_win;
    logic vs_win;
    logic at_origin;

    // Decode the current raster position into wrap, active and sync windows.
    always_comb begin
        h_wrap    = (hcnt == H_LAST);
        v_wrap    = h_wrap && (vcnt == V_LAST);
        act       = (hcnt < H_ACT) && (vcnt < V_ACT);
        hs_win    = (hcnt >= HS_BEG) && (hcnt < HS_END);
        // vcnt is constant across a line, so vsync naturally covers whole lines.
        vs_win    = (vcnt >= VS_BEG) && (vcnt < VS_END);
        at_origin = (hcnt == '0) && (vcnt == '0);
    end

    // Horizontal and vertical timing counters, advanced only on the pixel strobe.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours; blocking here would create
    // order-dependent simulation and a mismatch against synthesis.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                hcnt <= '0;
                vcnt <= v_wrap ? '0 : vcnt + VW'(1);
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

    // Linear read address: steps through active pixels, holds in blanking and
    // reloads zero at the end of the frame, so no line*width product is needed.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            vram_addr <= '0;
        end else if (pix_ce) begin
            if (v_wrap) begin
                vram_addr <= '0;
            end else if (act) begin
                vram_addr <= vram_addr + 17'd1;
            end
        end
    end

    // Output stage: the address for this position was issued on the previous
    // strobe, so vram_q already holds its pixel and all outputs share one delay.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            video <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            de    <= 1'b0;
        end else if (pix_ce) begin
            de    <= act;
            video <= act & enable & (vram_q ^ invert);
            hsync <= hs_win;
            vsync <= vs_win;
        end
    end

    // Frame marker is a single-clock pulse rather than held across the pixel.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & at_origin;
        end
    end

endmodule

// File: tb/tb_kgd_scanout.sv
// tb_kgd_scanout: directed scoreboard bench for kgd_scanout on a small raster.
module tb_kgd_scanout;

    localparam int HA  = 8;
    localparam int HT  = 12;
    localparam int HSS = 9;
    localparam int HSW = 2;
    localparam int VA  = 4;
    localparam int VT  = 6;
    localparam int VSS = 4;
    localparam int VSW = 1;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b0;
    logic        enable = 1'b1;
    logic        invert = 1'b0;
    logic [16:0] vram_addr;
    logic        vram_q = 1'b0;
    logic        video, hsync, vsync, de, frame_start;

    kgd_scanout #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_WIDTH(HSW),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_WIDTH(VSW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pix_ce     (pix_ce),
        .enable     (enable),
        .invert     (invert),
        .vram_addr  (vram_addr),
        .vram_q     (vram_q),
        .video      (video),
        .hsync      (hsync),
        .vsync      (vsync),
        .de         (de),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Port B model: 1-clock latency, mem[a] = a[0].
    always @(posedge clk) vram_q <= vram_addr[0];

    typedef struct packed {
        logic        video;
        logic        hsync;
        logic        vsync;
        logic        de;
        logic        fs;
        logic [16:0] addr;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   mh = 0;
    int   mv = 0;
    int   checks = 0;
    int   errors = 0;
    int   de_cnt = 0;
    int   fs_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Address the counter should hold when the raster sits at (h, v).
    function automatic int addr_at(input int h, input int v);
        if (v < VA) return v * HA + ((h < HA) ? h : HA);
        return HA * VA;
    endfunction

    // Drive one pixel strobe preceded by nothing and followed by gap idle clocks.
    task automatic pix(input int gap);
        exp_t e;
        exp_t g;
        int   pa;
        pa      = mv * HA + mh;
        e.de    = (mh < HA) && (mv < VA);
        e.video = e.de && enable && ((pa % 2 == 1) ^ invert);
        e.hsync = (mh >= HSS) && (mh < HSS + HSW);
        e.vsync = (mv >= VSS) && (mv < VSS + VSW);
        e.fs    = (mh == 0) && (mv == 0);
        mh++;
        if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
        end
        e.addr = 17'(addr_at(mh, mv));
        sb.push_back(e);

        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            check("video", video, g.video);
            check("hsync", hsync, g.hsync);
            check("vsync", vsync, g.vsync);
            check("de", de, g.de);
            check("frame_start", frame_start, g.fs);
            check("vram_addr", vram_addr, g.addr);
            last = g;
            de_cnt += int'(g.de);
            fs_cnt += int'(g.fs);
        end
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            check("hold", {video, hsync, vsync, de, frame_start, vram_addr},
                  {last.video, last.hsync, last.vsync, last.de, 1'b0, last.addr});
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check(tag, {video, hsync, vsync, de, frame_start, vram_addr}, 32'd0);
    endtask

    task automatic frame(input bit irregular, input string tag);
        de_cnt = 0;
        fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (irregular) pix(int'($urandom_range(1, 4)));
            else           pix(1);
        end
        check({tag, "_de_count"}, de_cnt, VA * HA);
        check({tag, "_fs_count"}, fs_cnt, 1);
        check({tag, "_addr_wrap"}, vram_addr, 0);
    endtask

    initial begin
        // Reset held for 3 clocks; outputs must be zero throughout.
        #1;
        check_idle_zero("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_idle_zero("reset_hold");
        end
        rst = 1'b0;

        // Regular strobe, plain polarity.
        frame(1'b0, "regular");

        // Irregular strobe gaps must not change the sampled stream.
        frame(1'b1, "irregular");

        // Frozen state with a long idle stretch.
        pix(20);

        // Realign to a frame start before the polarity tests.
        for (int i = 0; i < FRAME && !(mh == 0 && mv == 0); i++) pix(1);
        check("realign", mh * 100 + mv, 0);

        invert = 1'b1;
        frame(1'b0, "invert");

        invert = 1'b0;
        enable = 1'b0;
        frame(1'b0, "disable");

        // Mid-frame enable toggle takes effect on the next strobe.
        enable = 1'b1;
        for (int i = 0; i < FRAME && !(mh == 5 && mv == 2); i++) pix(1);
        check("reach_5_2", mh * 100 + mv, 502);

        // Asynchronous reset mid-frame discards the partial frame.
        rst = 1'b1;
        #1;
        check_idle_zero("midreset_async");
        @(posedge clk);
        #1;
        check_idle_zero("midreset_hold");
        rst = 1'b0;
        mh = 0;
        mv = 0;
        sb.delete();
        fs_cnt = 0;
        for (int i = 0; i < 20; i++) pix(1);
        check("midreset_fs_count", fs_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kgd_scanout.md
# kgd_scanout

Raster scan-out reader for the КГД graphics subsystem. It owns the read port (port B) of the dual-port КГД video RAM, which stores 1 bit per pixel. It generates horizontal and vertical timing counters and issues linear pixel addresses in raster order. It aligns the returned bit with registered sync and data-enable outputs to form the monochrome video stream. The bus side writes through port A independently; this block never writes.

## Interface
- H_ACTIVE, 400, visible pixels per line
- H_TOTAL, 512, pixels per line including blanking (> H_ACTIVE)
- HS_START, 432, horizontal counter value where hsync begins
- HS_WIDTH, 48, hsync length in pixels
- V_ACTIVE, 288, visible lines per frame (H_ACTIVE*V_ACTIVE ≤ 131072)
- V_TOTAL, 312, lines per frame including blanking (> V_ACTIVE)
- VS_START, 292, line where vsync begins
- VS_WIDTH, 3, vsync length in lines
- wb_clk_i  in  1  system clock; video RAM port B is clocked by the same clock
- wb_rst_i  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel strobe; never high on two consecutive clocks
- enable  in  1  display on; 0 forces video low, timing keeps running
- invert  in  1  invert pixel polarity in the active area
- vram_addr  out  17  port B read address (registered)
- vram_q  in  1  port B read data, valid one clock after the address
- video  out  1  pixel output
- hsync  out  1  horizontal sync, active-high (pad inverts if needed)
- vsync  out  1  vertical sync, active-high
- de  out  1  active-area flag aligned with video
- frame_start  out  1  one-clock pulse with the first output pixel of a frame

## Operation
- Counters: hcnt in 0..H_TOTAL-1 and vcnt in 0..V_TOTAL-1 advance only on pix_ce.
  - hcnt wraps to 0 after H_TOTAL-1; vcnt increments on hcnt wrap.
  - vcnt wraps to 0 after V_TOTAL-1.
- Active area: act = (hcnt < H_ACTIVE) & (vcnt < V_ACTIVE).
- Address counter vram_addr (17 bit):
  - Increments on pix_ce when act.
  - Holds during blanking, so it reaches line L*H_ACTIVE at the start of line L.
  - Loads 0 on the pix_ce that wraps vcnt.
  - No multiplier is used.
- Output stage, registered on each pix_ce from the current counters and vram_q:
  - de ← act
  - video ← act & enable & (vram_q ^ invert)
  - hsync ← HS_START ≤ hcnt < HS_START+HS_WIDTH
  - vsync ← VS_START ≤ vcnt < VS_START+VS_WIDTH, held for whole lines
  - frame_start ← (hcnt==0 & vcnt==0)
- Outputs hold between pix_ce strobes. frame_start is the exception: it drops the clock after it is set.
- enable and invert are sampled per pixel; a change takes effect on the next pix_ce.

## Timing
- Reset (asynchronous):
  - hcnt, vcnt and vram_addr = 0.
  - video, hsync, vsync, de and frame_start = 0.
  - First pix_ce after release outputs pixel (0,0) with frame_start=1.
- RAM latency: vram_addr updates at pix_ce edge k. The RAM samples it at edge k+1, and vram_q is captured at the next pix_ce, which is no earlier than k+2. The minimum 2-clock pixel period guarantees valid data.
- Output latency: one pixel strobe from counter state to pins. video, de, hsync and vsync share the same delay.
- Simultaneous hcnt and vcnt wrap: vram_addr loads 0 and frame_start fires on the next pix_ce. There is no stale address H_ACTIVE*V_ACTIVE in the active area.
- pix_ce held low: all state frozen indefinitely.
- Reset mid-frame: immediate return to (0,0); the partial frame is discarded.

## Test plan
Bench setup: H_ACTIVE=8, H_TOTAL=12, HS_START=9, HS_WIDTH=2, V_ACTIVE=4, V_TOTAL=6, VS_START=4, VS_WIDTH=1. RAM model has 1-clock latency; mem[a]=a[0]; pix_ce every 2nd clock.

- Reset asserted for 3 clocks → all outputs 0 and vram_addr=0 during reset. First pix_ce gives frame_start=1, de=1, video=0.
- Address sequence → lines 0..3 issue 0..7, 8..15, 16..23, 24..31. vram_addr holds 8 during line 0 blanking and returns to 0 after 72 pix_ce. video pattern per line is 0,1,0,1,0,1,0,1.
- Sync timing → hsync high for output pixels h=9,10 of every line, and vsync high for all 12 pixels of line 4. de is high exactly 32 times per frame. frame_start occurs once per 72 pix_ce.
- Irregular pix_ce (random gaps of 1–4 idle clocks) → output sequence sampled at pix_ce is identical to the regular case.
- invert=1 → active video is 1,0,1,0…, and video=0 in blanking. enable=0 → video=0 with hsync, vsync and de unchanged.
- Reset at h=5, v=2 → next pix_ce outputs (0,0) with frame_start=1, and address sequence restarts at 0.
